sensor_qualifier: RTL and testbench
===================================

SENSOR_QUALIFIER -- requirements
Module: sensor_qualifier

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized cycles item presence must hold to count as a change; legal 1..15.
REQ-002 Parameter SAMPLE_LEN, default 5: length of the sensor sampling window in cycles; odd, legal 1..15.
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 item_present_i  input  1  raw, asynchronous part-on-conveyor sensor.
REQ-006 weight_raw_i, size_raw_i, color_raw_i  input  1 each  raw, asynchronous pass/fail sensor levels.
REQ-007 weight_ok_o, size_ok_o, color_ok_o  output  1 each  qualified flags that feed the grading FSM.
REQ-008 valid_o  output  1  one-cycle pulse when new flags are latched.
REQ-009 abort_o  output  1  one-cycle pulse when a measurement is abandoned.
REQ-010 busy_o  output  1  high whenever the state is not IDLE.

Function
REQ-011 All four raw inputs SHALL pass through two-flop synchronizers; the synchronized value is used 2 cycles after the raw edge.
REQ-012 FSM states SHALL be IDLE, SETTLE, SAMPLE, HOLD, LEAVE; the encoding is free.
REQ-013 IDLE: synchronized present=1 -> SETTLE, debounce counter = 1.
REQ-014 SETTLE: present=1 increments the counter; when the count reaches DEBOUNCE_CYCLES -> SAMPLE; present=0 -> IDLE, counter cleared, no pulse.
REQ-015 SAMPLE: runs exactly SAMPLE_LEN cycles; a 4-bit per-sensor counter counts the cycles with the synchronized sensor =1.
REQ-016 SAMPLE with present=0 on any cycle -> IDLE; abort_o pulses for 1 cycle; flag outputs keep their prior values; valid_o stays 0.
REQ-017 End of SAMPLE: the flags SHALL be latched from the counters (rule per REQ-027/028) and valid_o pulses on the same cycle the flags update -> HOLD.
REQ-018 Latency: with stable inputs, valid_o SHALL assert exactly 2+DEBOUNCE_CYCLES+SAMPLE_LEN cycles after the first edge at which raw present is high (11 with defaults).
REQ-019 HOLD: the flags stay constant; present=0 -> LEAVE, counter = 1.
REQ-020 LEAVE: present=0 increments the counter; reaching DEBOUNCE_CYCLES -> IDLE, and all three flags clear to 0 on that transition; present=1 -> HOLD, with the flags unchanged.
REQ-021 A new measurement SHALL only start from IDLE, so one item produces at most one valid_o.
REQ-022 valid_o and abort_o SHALL never be high in the same cycle.
REQ-023 Counters SHALL saturate and never wrap.

Reset
REQ-024 rst=1 at a clock edge -> state IDLE, all counters 0, synchronizer flops 0.
REQ-025 All outputs SHALL be 0 in the cycle after reset, including weight_ok_o, size_ok_o, color_ok_o, valid_o, abort_o and busy_o.
REQ-026 Reset asserted mid-SETTLE, mid-SAMPLE or mid-HOLD SHALL abandon the item without an abort_o pulse.

Configuration
REQ-027 With QUAL_MAJORITY_EN defined: flag = 1 when the sensor's ones count > SAMPLE_LEN/2 (3 of 5 with defaults).
REQ-028 Without QUAL_MAJORITY_EN: flag = 1 only when the ones count = SAMPLE_LEN (unanimous); every other behaviour is identical.

Verification (DEBOUNCE_CYCLES=4, SAMPLE_LEN=5)
REQ-029 Present held 1, weight=1, size=1, color=0 constant -> valid_o single pulse 11 cycles after present rises; flags 1,1,0; busy_o high throughout.
REQ-030 Present high for 3 cycles then low -> no valid_o, no abort_o; busy_o returns to 0; flags stay 0.
REQ-031 weight high on 3 of the 5 sample cycles -> weight_ok_o=1 with QUAL_MAJORITY_EN defined, 0 without it.
REQ-032 Present drops on the 3rd SAMPLE cycle -> abort_o single pulse, no valid_o, previous flags kept, state IDLE.
REQ-033 From HOLD, present low for 6 consecutive raw cycles -> flags clear to 0 exactly 2+4 cycles after the fall; a present low of only 2 cycles -> flags unchanged.
REQ-034 rst pulsed while in HOLD with flags 1,1,1 -> next cycle all outputs 0; a subsequent item measures normally.

Source files
------------

// File: rtl/sensor_qualifier.sv
// sensor_qualifier: debounces item presence, samples three pass/fail sensors and latches qualified flags.
// Define QUAL_MAJORITY_EN for majority-vote flags; the default build requires unanimous samples.
module sensor_qualifier #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SAMPLE_LEN      = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic item_present_i,
   input  logic weight_raw_i,
   input  logic size_raw_i,
   input  logic color_raw_i,
   output logic weight_ok_o,
   output logic size_ok_o,
   output logic color_ok_o,
   output logic valid_o,
   output logic abort_o,
   output logic busy_o
);
`ifdef QUAL_MAJORITY_EN
   localparam logic [3:0] THRESH = 4'(SAMPLE_LEN / 2 + 1);
`else
   localparam logic [3:0] THRESH = 4'(SAMPLE_LEN);
`endif
   localparam logic [3:0] DEB = 4'(DEBOUNCE_CYCLES);
   localparam logic [3:0] LAST = 4'(SAMPLE_LEN - 1);

   typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, HOLD, LEAVE} state_t;

   state_t state;
   logic [3:0] s1, s2;
   logic [3:0] dcnt, scnt;
   logic [2:0][3:0] ones, ones_nx;
   logic [2:0] flags, ok;
   logic present;

   assign present = s2[3];
   assign {weight_ok_o, size_ok_o, color_ok_o} = flags;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= {item_present_i, weight_raw_i, size_raw_i, color_raw_i};
         s2 <= s1;
      end
   end

   // ones_nx includes the current cycle so the final sample counts toward the flags
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         ones_nx[i] = ones[i] + {3'b000, s2[i] && ones[i] != 4'hf};
         ok[i]      = ones_nx[i] >= THRESH;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         dcnt    <= '0;
         scnt    <= '0;
         ones    <= '0;
         flags   <= '0;
         valid_o <= 1'b0;
         abort_o <= 1'b0;
         busy_o  <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         abort_o <= 1'b0;
         case (state)
            IDLE: if (present) begin
               state  <= SETTLE;
               dcnt   <= 4'd1;
               busy_o <= 1'b1;
            end
            SETTLE: if (!present) begin
               state  <= IDLE;
               dcnt   <= '0;
               busy_o <= 1'b0;
            end else if (dcnt == DEB) begin
               state <= SAMPLE;
               scnt  <= '0;
               ones  <= '0;
            end else dcnt <= dcnt + 4'd1;
            SAMPLE: if (!present) begin
               state   <= IDLE;
               dcnt    <= '0;
               abort_o <= 1'b1;
               busy_o  <= 1'b0;
            end else if (scnt == LAST) begin
               state   <= HOLD;
               flags   <= ok;
               valid_o <= 1'b1;
               ones    <= ones_nx;
            end else begin
               scnt <= scnt + 4'd1;
               ones <= ones_nx;
            end
            HOLD: if (!present) begin
               state <= LEAVE;
               dcnt  <= 4'd1;
            end
            LEAVE: if (present) state <= HOLD;
            else if (dcnt == DEB) begin
               state  <= IDLE;
               dcnt   <= '0;
               flags  <= '0;
               busy_o <= 1'b0;
            end else dcnt <= dcnt + 4'd1;
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sensor_qualifier.sv
// tb_sensor_qualifier: random segment stimulus checked against a run-length reference model.
module tb_sensor_qualifier;
   localparam int D = 4;
   localparam int S = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic item_present_i = 1'b0, weight_raw_i = 1'b0, size_raw_i = 1'b0, color_raw_i = 1'b0;
   logic weight_ok_o, size_ok_o, color_ok_o, valid_o, abort_o, busy_o;

   sensor_qualifier #(.DEBOUNCE_CYCLES(D), .SAMPLE_LEN(S)) dut (
      .clk(clk), .rst(rst), .item_present_i(item_present_i),
      .weight_raw_i(weight_raw_i), .size_raw_i(size_raw_i), .color_raw_i(color_raw_i),
      .weight_ok_o(weight_ok_o), .size_ok_o(size_ok_o), .color_ok_o(color_ok_o),
      .valid_o(valid_o), .abort_o(abort_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;

   task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
      end
   endtask

   // Reference: raw inputs reach the decision logic two edges late; an item is
   // judged by the length of the present run and the sensor samples inside it.
   bit [3:0] h1, h2;
   int run, zrun, win[3];
   bit hold, m_valid, m_abort, m_busy;
   bit [2:0] m_flags;

   function automatic bit qualifies(int n);
`ifdef QUAL_MAJORITY_EN
      return 2 * n > S;
`else
      return n == S;
`endif
   endfunction

   task automatic model_step(input bit r, input bit [3:0] raw);
      bit [3:0] sv;
      sv = h2;
      h2 = h1;
      h1 = raw;
      m_valid = 0;
      m_abort = 0;
      if (r) begin
         h1 = 0; h2 = 0; run = 0; zrun = 0; hold = 0; m_flags = 0; m_busy = 0;
         win = '{0, 0, 0};
         return;
      end
      if (!hold) begin
         if (sv[3]) begin
            run++;
            if (run >= D + 2) for (int i = 0; i < 3; i++) win[i] += sv[i];
            if (run == D + 1 + S) begin
               for (int i = 0; i < 3; i++) m_flags[i] = qualifies(win[i]);
               m_valid = 1; hold = 1; zrun = 0;
            end
         end else begin
            if (run >= D + 1) m_abort = 1;
            run = 0;
            win = '{0, 0, 0};
         end
      end else if (!sv[3]) begin
         zrun++;
         if (zrun == D + 1) begin
            m_flags = 0; hold = 0; run = 0;
            win = '{0, 0, 0};
         end
      end else zrun = 0;
      m_busy = hold || run > 0;
   endtask

   initial begin
      bit seg_pres = 0;
      int seg_left = 0;
      bit [2:0] base = 0;
      bit [2:0] noise;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (c >= 2) rst = ($urandom_range(0, 299) == 0);
         if (seg_left == 0) begin
            seg_pres = ~seg_pres;
            seg_left = seg_pres ? $urandom_range(1, 24) : $urandom_range(1, 9);
            base = 3'($urandom);
         end
         seg_left--;
         noise = 3'($urandom) & 3'($urandom) & 3'($urandom);
         item_present_i = seg_pres;
         {weight_raw_i, size_raw_i, color_raw_i} = base ^ noise;
         @(posedge clk);
         model_step(rst, {item_present_i, weight_raw_i, size_raw_i, color_raw_i});
         #1;
         check("flags", {weight_ok_o, size_ok_o, color_ok_o}, m_flags);
         check("valid", {2'b00, valid_o}, {2'b00, m_valid});
         check("abort", {2'b00, abort_o}, {2'b00, m_abort});
         check("busy", {2'b00, busy_o}, {2'b00, m_busy});
         check("valid_abort_excl", {2'b00, valid_o & abort_o}, 3'b000);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
